flow_ctrl: RTL and testbench

FLOW_CTRL -- requirements
Module: flow_ctrl

---
 rtl/flow_ctrl_pkg.sv | 43 ++++
 rtl/flow_cnt.sv | 47 ++++
 rtl/flow_ctrl.sv | 146 ++++++++++++++
 tb/tb_flow_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: flow command encodings,
// FSM state encodings and the counter width helper.
package flow_ctrl_pkg;

    localparam int FLOW_WIDTH = 2;

    typedef enum logic [1:0] {
        FLOW_WORK    = 2'b00,
        FLOW_STOP    = 2'b01,
        FLOW_REFRESH = 2'b10
    } flow_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MC_WAIT    = 2'b01,
        ST_TRAP_FLUSH = 2'b10
    } state_e;

    // One command per pipeline register, PC first.
    typedef struct packed {
        flow_e pc;
        flow_e id;
        flow_e ex;
        flow_e ast;
        flow_e wb;
    } flow_cmd_t;

    localparam flow_cmd_t CMD_WORK  = '{FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK};
    localparam flow_cmd_t CMD_LOAD  = '{FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    localparam flow_cmd_t CMD_JUMP  = '{FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    localparam flow_cmd_t CMD_MC    = '{FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK};
    localparam flow_cmd_t CMD_TRAP  = '{FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_STOP};
    localparam flow_cmd_t CMD_FLUSH = '{FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK};
    localparam flow_cmd_t CMD_RESET = '{FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH};

    // Bits needed to hold max(a, b) - 1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/flow_cnt.sv
// Shared wait/flush counter: clear, load, increment or decrement, with a zero flag.
module flow_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count; the controller never requests a step past either end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1'b1);
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: turns hazard, jump, multi-cycle and trap events into
// per-stage WORK/STOP/REFRESH commands, with a timeout on multi-cycle ops.
module flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT        = 64,
    parameter int TRAP_FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_use_i,
    input  logic                  jump_i,
    input  logic                  mc_start_i,
    input  logic                  mc_done_i,
    input  logic                  trap_i,
    output logic [FLOW_WIDTH-1:0] flow_pc_o,
    output logic [FLOW_WIDTH-1:0] flow_id_o,
    output logic [FLOW_WIDTH-1:0] flow_ex_o,
    output logic [FLOW_WIDTH-1:0] flow_as_o,
    output logic [FLOW_WIDTH-1:0] flow_wb_o,
    output logic                  busy_o,
    output logic                  mc_timeout_o
);

    localparam int CNT_W = cnt_width(MC_TIMEOUT, TRAP_FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(TRAP_FLUSH_CYCLES - 1);

    state_e     state_q;
    state_e     state_d;
    flow_cmd_t  cmd_s;
    flow_cmd_t  out_s;
    logic       cnt_clr_s;
    logic       cnt_load_s;
    logic       cnt_inc_s;
    logic       cnt_dec_s;
    logic       timeout_s;
    logic [CNT_W-1:0] cnt_s;
    logic       cnt_zero_s;

    flow_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr_s),
        .load_i     (cnt_load_s),
        .load_val_i (FLUSH_LAST),
        .inc_i      (cnt_inc_s),
        .dec_i      (cnt_dec_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and stage commands; trap always wins.
    always_comb begin
        state_d    = state_q;
        cmd_s      = CMD_WORK;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        cnt_dec_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (trap_i) begin
                    cmd_s      = CMD_TRAP;
                    cnt_load_s = 1'b1;
                    state_d    = ST_TRAP_FLUSH;
                end else if (mc_start_i) begin
                    cmd_s     = CMD_MC;
                    cnt_clr_s = 1'b1;
                    state_d   = ST_MC_WAIT;
                end else if (jump_i) begin
                    cmd_s = CMD_JUMP;
                end else if (load_use_i) begin
                    cmd_s = CMD_LOAD;
                end else begin
                    cmd_s = CMD_WORK;
                end
            end
            ST_MC_WAIT: begin
                if (trap_i) begin
                    cmd_s      = CMD_TRAP;
                    cnt_load_s = 1'b1;
                    state_d    = ST_TRAP_FLUSH;
                end else if (mc_done_i) begin
                    cmd_s   = CMD_WORK;
                    state_d = ST_RUN;
                end else if (cnt_s == MC_LAST) begin
                    // A hung multi-cycle unit is treated exactly like a trap.
                    timeout_s  = 1'b1;
                    cmd_s      = CMD_TRAP;
                    cnt_load_s = 1'b1;
                    state_d    = ST_TRAP_FLUSH;
                end else begin
                    cmd_s     = CMD_MC;
                    cnt_inc_s = 1'b1;
                end
            end
            ST_TRAP_FLUSH: begin
                if (trap_i) begin
                    cmd_s      = CMD_TRAP;
                    cnt_load_s = 1'b1;
                end else if (cnt_zero_s) begin
                    cmd_s   = CMD_FLUSH;
                    state_d = ST_RUN;
                end else begin
                    cmd_s     = CMD_FLUSH;
                    cnt_dec_s = 1'b1;
                end
            end
            default: begin
                cmd_s   = CMD_WORK;
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset overrides every command so the pipeline holds PC and empties the stages.
    always_comb begin
        if (rst) begin
            out_s        = CMD_RESET;
            busy_o       = 1'b0;
            mc_timeout_o = 1'b0;
        end else begin
            out_s        = cmd_s;
            busy_o       = (state_q == ST_MC_WAIT) || (state_q == ST_TRAP_FLUSH);
            mc_timeout_o = timeout_s;
        end
    end

    assign flow_pc_o = out_s.pc;
    assign flow_id_o = out_s.id;
    assign flow_ex_o = out_s.ex;
    assign flow_as_o = out_s.ast;
    assign flow_wb_o = out_s.wb;

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed and sparse-random bench for flow_ctrl against a counting model of
// the wait/flush behaviour, plus literal checks of the listed scenarios.
module tb_flow_ctrl;

    localparam int MCT = 8;
    localparam int TFC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use = 1'b0, jump = 1'b0, mc_start = 1'b0, mc_done = 1'b0, trap = 1'b0;
    logic [1:0] f_pc, f_id, f_ex, f_as, f_wb;
    logic busy, mc_to;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: either waiting on a multi-cycle op (with cycles already waited) or flushing
    bit waiting   = 1'b0;
    int wait_n    = 0;
    int flush_left = 0;

    localparam logic [9:0] P_WORK  = 10'b00_00_00_00_00;
    localparam logic [9:0] P_LOAD  = 10'b01_01_10_00_00;
    localparam logic [9:0] P_JUMP  = 10'b00_10_10_00_00;
    localparam logic [9:0] P_MC    = 10'b01_01_01_10_00;
    localparam logic [9:0] P_TRAP  = 10'b00_10_10_10_01;
    localparam logic [9:0] P_FLUSH = 10'b00_10_10_10_00;
    localparam logic [9:0] P_RESET = 10'b01_10_10_10_10;

    flow_ctrl #(.MC_TIMEOUT(MCT), .TRAP_FLUSH_CYCLES(TFC)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_use_i   (load_use),
        .jump_i       (jump),
        .mc_start_i   (mc_start),
        .mc_done_i    (mc_done),
        .trap_i       (trap),
        .flow_pc_o    (f_pc),
        .flow_id_o    (f_id),
        .flow_ex_o    (f_ex),
        .flow_as_o    (f_as),
        .flow_wb_o    (f_wb),
        .busy_o       (busy),
        .mc_timeout_o (mc_to)
    );

    always #5 clk = ~clk;

    // expected {flow[9:0], busy, timeout} for the current model state and inputs
    function automatic logic [11:0] model_out();
        bit in_flush;
        in_flush = (flush_left > 0);
        if (rst)                 return {P_RESET, 1'b0, 1'b0};
        if (trap)                return {P_TRAP, waiting | in_flush, 1'b0};
        if (waiting) begin
            if (mc_done)             return {P_WORK, 1'b1, 1'b0};
            if (wait_n == MCT - 1)   return {P_TRAP, 1'b1, 1'b1};
            return {P_MC, 1'b1, 1'b0};
        end
        if (in_flush)            return {P_FLUSH, 1'b1, 1'b0};
        if (mc_start)            return {P_MC, 1'b0, 1'b0};
        if (jump)                return {P_JUMP, 1'b0, 1'b0};
        if (load_use)            return {P_LOAD, 1'b0, 1'b0};
        return {P_WORK, 1'b0, 1'b0};
    endfunction

    // model update on each rising edge
    always @(posedge clk) begin
        if (rst) begin
            waiting    <= 1'b0;
            flush_left <= 0;
        end else if (trap) begin
            waiting    <= 1'b0;
            flush_left <= TFC;
        end else if (waiting) begin
            if (mc_done) begin
                waiting <= 1'b0;
            end else if (wait_n == MCT - 1) begin
                waiting    <= 1'b0;
                flush_left <= TFC;
            end else begin
                wait_n <= wait_n + 1;
            end
        end else if (flush_left > 0) begin
            flush_left <= flush_left - 1;
        end else if (mc_start) begin
            waiting <= 1'b1;
            wait_n  <= 0;
        end
    end

    // compare every cycle against the model
    always @(negedge clk) begin
        logic [11:0] e;
        if (chk_en) begin
            e = model_out();
            total++;
            if ({f_pc, f_id, f_ex, f_as, f_wb} !== e[11:2]) begin
                bad++;
                $display("FAIL model_flow t=%0t got=%b expected=%b", $time,
                         {f_pc, f_id, f_ex, f_as, f_wb}, e[11:2]);
            end
            total++;
            if (busy !== e[1]) begin
                bad++;
                $display("FAIL model_busy t=%0t got=%b expected=%b", $time, busy, e[1]);
            end
            total++;
            if (mc_to !== e[0]) begin
                bad++;
                $display("FAIL model_timeout t=%0t got=%b expected=%b", $time, mc_to, e[0]);
            end
        end
    end

    task automatic drive(input logic r, input logic t, input logic ms, input logic md,
                         input logic j, input logic lu);
        @(posedge clk);
        #1;
        rst = r; trap = t; mc_start = ms; mc_done = md; jump = j; load_use = lu;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string nm, input logic [9:0] ef, input logic eb, input logic et);
        total++;
        if ({f_pc, f_id, f_ex, f_as, f_wb} !== ef || busy !== eb || mc_to !== et) begin
            bad++;
            $display("FAIL %s got flow=%b busy=%b to=%b expected flow=%b busy=%b to=%b", nm,
                     {f_pc, f_id, f_ex, f_as, f_wb}, busy, mc_to, ef, eb, et);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("reset", 10'b01_10_10_10_10, 1'b0, 1'b0);
        idle();
        pin("run_idle", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // load-use bubble
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pin("load_use", 10'b01_01_10_00_00, 1'b0, 1'b0);
        idle();
        pin("after_load_use", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // jump beats load-use
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        pin("jump_load_use", 10'b00_10_10_00_00, 1'b0, 1'b0);

        // divide finishing after five wait cycles
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pin("div_start", 10'b01_01_01_10_00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            pin("div_wait", 10'b01_01_01_10_00, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pin("div_done", 10'b00_00_00_00_00, 1'b1, 1'b0);
        idle();
        pin("div_back_run", 10'b00_00_00_00_00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pin("done_in_run", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // timeout on the eighth wait cycle
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            idle();
            pin("to_wait", 10'b01_01_01_10_00, 1'b1, 1'b0);
        end
        idle();
        pin("to_pulse", 10'b00_10_10_10_01, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            pin("to_flush", 10'b00_10_10_10_00, 1'b1, 1'b0);
        end
        idle();
        pin("to_back_run", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // trap on the third wait cycle with done
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pin("trap_mid_div", 10'b00_10_10_10_01, 1'b1, 1'b0);
        idle();
        pin("trap_flush1", 10'b00_10_10_10_00, 1'b1, 1'b0);
        idle();
        pin("trap_flush2", 10'b00_10_10_10_00, 1'b1, 1'b0);
        idle();
        pin("trap_back_run", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // trap restarts a flush in progress
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pin("trap_run", 10'b00_10_10_10_01, 1'b0, 1'b0);
        idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("trap_reload", 10'b00_10_10_10_01, 1'b1, 1'b0);
        idle();
        idle();
        pin("reload_flush2", 10'b00_10_10_10_00, 1'b1, 1'b0);
        idle();
        pin("reload_back_run", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // reset in the middle of a flush
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("rst_mid_flush", 10'b01_10_10_10_10, 1'b0, 1'b0);
        idle();
        pin("rst_released", 10'b00_00_00_00_00, 1'b0, 1'b0);

        // sparse random traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 150) == 0, ($urandom % 40) == 0, ($urandom % 8) == 0,
                  ($urandom % 12) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
